// File: rtl/fp_add_arbiter.sv
// Round-robin arbiter sharing one combinational single-precision adder among NUM_REQ requesters.
// Optional statistics outputs (op_count, stall_count) are enabled by defining FP_ADD_ARBITER_STATS_EN.

module floating_unit (
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic        i_sub,
    output logic [31:0] o_sum
);
    logic        w_sa, w_sb, w_sl, w_ss, w_swap;
    logic        w_nan_a, w_nan_b, w_inf_a, w_inf_b;
    logic [7:0]  w_el, w_es, w_d;
    logic [23:0] w_ml, w_ms, w_mant;
    logic [26:0] w_small, w_mask;
    logic [27:0] w_acc;
    logic [24:0] w_rnd;
    logic [9:0]  w_exp;

    always_comb begin
        w_sa    = i_a[31];
        w_sb    = i_b[31] ^ i_sub;
        w_nan_a = (i_a[30:23] == 8'hFF) && (i_a[22:0] != 23'd0);
        w_nan_b = (i_b[30:23] == 8'hFF) && (i_b[22:0] != 23'd0);
        w_inf_a = (i_a[30:23] == 8'hFF) && (i_a[22:0] == 23'd0);
        w_inf_b = (i_b[30:23] == 8'hFF) && (i_b[22:0] == 23'd0);
        // order operands by magnitude so the subtraction never goes negative
        w_swap  = i_b[30:0] > i_a[30:0];
        w_sl    = w_swap ? w_sb : w_sa;
        w_ss    = w_swap ? w_sa : w_sb;
        w_el    = w_swap ? i_b[30:23] : i_a[30:23];
        w_es    = w_swap ? i_a[30:23] : i_b[30:23];
        w_ml    = w_swap ? {|i_b[30:23], i_b[22:0]} : {|i_a[30:23], i_a[22:0]};
        w_ms    = w_swap ? {|i_a[30:23], i_a[22:0]} : {|i_b[30:23], i_b[22:0]};
        if (w_el == 8'd0) w_el = 8'd1;
        if (w_es == 8'd0) w_es = 8'd1;
        w_d     = w_el - w_es;
        w_mask  = (w_d > 8'd26) ? '1 : ((27'd1 << w_d) - 27'd1);
        w_small = (w_d > 8'd26) ? 27'd0 : ({w_ms, 3'b000} >> w_d);
        w_small[0] = w_small[0] | (|({w_ms, 3'b000} & w_mask));
        if (w_sl == w_ss) w_acc = {1'b0, w_ml, 3'b000} + {1'b0, w_small};
        else              w_acc = {1'b0, w_ml, 3'b000} - {1'b0, w_small};
        w_exp = {2'b00, w_el};
        if (w_acc[27]) begin
            w_acc = {1'b0, w_acc[27:2], w_acc[1] | w_acc[0]};
            w_exp = w_exp + 10'd1;
        end
        for (int i = 0; i < 26; i++) begin
            if (!w_acc[26] && (w_exp > 10'd1)) begin
                w_acc = w_acc << 1;
                w_exp = w_exp - 10'd1;
            end
        end
        // round to nearest, ties to even
        w_rnd = {1'b0, w_acc[26:3]} + {24'd0, w_acc[2] & (w_acc[1] | w_acc[0] | w_acc[3])};
        if (w_rnd[24]) begin
            w_mant = w_rnd[24:1];
            w_exp  = w_exp + 10'd1;
        end else begin
            w_mant = w_rnd[23:0];
        end
        if (w_acc == 28'd0)         o_sum = {w_sl & w_ss, 31'd0};
        else if (w_exp >= 10'd255)  o_sum = {w_sl, 8'hFF, 23'd0};
        else                        o_sum = {w_sl, (w_mant[23] ? w_exp[7:0] : 8'd0), w_mant[22:0]};
        if (w_nan_a || w_nan_b || (w_inf_a && w_inf_b && (w_sa != w_sb))) o_sum = 32'h7FC00000;
        else if (w_inf_a)                                                   o_sum = {w_sa, 8'hFF, 23'd0};
        else if (w_inf_b)                                                   o_sum = {w_sb, 8'hFF, 23'd0};
    end
endmodule

// state | meaning
// IDLE  | arbitrating; req_ready asserted for the round-robin winner
// EXEC  | registered operands drive floating_unit; result captured at cycle end
// DONE  | out_valid held until out_ready
module fp_add_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 32,
    parameter int ID_W    = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    input  logic [NUM_REQ-1:0]       req_sub,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic [ID_W-1:0]          out_id
`ifdef FP_ADD_ARBITER_STATS_EN
    ,
    output logic [15:0]              op_count,
    output logic [15:0]              stall_count
`endif
);
    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t            r_state, w_next;
    logic [ID_W-1:0]   r_rr_ptr, r_id, w_gid, r_out_id;
    logic [WIDTH-1:0]  r_a, r_b, r_out_data, w_sum;
    logic              r_sub, w_found, w_accept;

    always_comb begin
        w_found = 1'b0;
        w_gid   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_found && req_valid[(int'(r_rr_ptr) + k) % NUM_REQ]) begin
                w_found = 1'b1;
                w_gid   = ID_W'((int'(r_rr_ptr) + k) % NUM_REQ);
            end
        end
    end

    always_comb begin
        w_next    = r_state;
        req_ready = '0;
        w_accept  = 1'b0;
        case (r_state)
            IDLE: if (w_found && !rst) begin
                req_ready[w_gid] = 1'b1;
                w_accept         = 1'b1;
                w_next           = EXEC;
            end
            EXEC:    w_next = DONE;
            DONE:    if (out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr   <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_sub      <= 1'b0;
            r_id       <= '0;
            r_out_data <= '0;
            r_out_id   <= '0;
        end else begin
            if (w_accept) begin
                r_a      <= req_a[int'(w_gid)*WIDTH +: WIDTH];
                r_b      <= req_b[int'(w_gid)*WIDTH +: WIDTH];
                r_sub    <= req_sub[w_gid];
                r_id     <= w_gid;
                r_rr_ptr <= (w_gid == ID_W'(NUM_REQ - 1)) ? '0 : w_gid + 1'b1;
            end
            if (r_state == EXEC) begin
                r_out_data <= w_sum;
                r_out_id   <= r_id;
            end
        end
    end

    floating_unit u_fpu (
        .i_a   (r_a),
        .i_b   (r_b),
        .i_sub (r_sub),
        .o_sum (w_sum)
    );

    assign out_valid = (r_state == DONE);
    assign out_data  = r_out_data;
    assign out_id    = r_out_id;

`ifdef FP_ADD_ARBITER_STATS_EN
    logic [15:0] r_op_count, r_stall_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op_count    <= '0;
            r_stall_count <= '0;
        end else begin
            if (out_valid && out_ready && (r_op_count != 16'hFFFF))
                r_op_count <= r_op_count + 16'd1;
            if ((r_state == DONE) && !out_ready && (r_stall_count != 16'hFFFF))
                r_stall_count <= r_stall_count + 16'd1;
        end
    end

    assign op_count    = r_op_count;
    assign stall_count = r_stall_count;
`endif
endmodule

// File: tb/tb_fp_add_arbiter.sv
// Directed self-checking bench for fp_add_arbiter: arbitration order, latency,
// back-pressure, reset recovery and a few hand-computed adder results.

module tb_fp_add_arbiter;
    logic         clk;
    logic         rst;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [127:0] req_a;
    logic [127:0] req_b;
    logic [3:0]   req_sub;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  out_data;
    logic [1:0]   out_id;
`ifdef FP_ADD_ARBITER_STATS_EN
    logic [15:0]  op_count;
    logic [15:0]  stall_count;
`endif

    int checks = 0;
    int errors = 0;

    fp_add_arbiter #(.NUM_REQ(4), .WIDTH(32), .ID_W(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_sub    (req_sub),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_id     (out_id)
`ifdef FP_ADD_ARBITER_STATS_EN
        ,
        .op_count   (op_count),
        .stall_count(stall_count)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic set_ops(input int i, input logic [31:0] a, input logic [31:0] b, input logic s);
        req_a[i*32 +: 32] = a;
        req_b[i*32 +: 32] = b;
        req_sub[i]        = s;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 4'hF;
        #1;
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready actual=%b required=0000", req_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid actual=%b required=0", out_valid); end
        checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data actual=%h required=00000000", out_data); end
        checks++; if (out_id !== 2'd0) begin errors++; $display("FAIL reset_out_id actual=%0d required=0", out_id); end
        @(negedge clk);
        req_valid = 4'h0;
        rst = 1'b0;
    endtask

    task automatic test_single_add();
        set_ops(0, 32'h40000000, 32'h40000000, 1'b0);
        out_ready = 1'b1;
        req_valid = 4'b0001;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL add_ready actual=%b required=0001", req_ready); end
        @(negedge clk);
        req_valid = 4'b0000;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL add_exec_valid actual=%b required=0", out_valid); end
        @(negedge clk);
        #1;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL add_latency actual=%b required=1", out_valid); end
        checks++; if (out_data !== 32'h40800000) begin errors++; $display("FAIL add_data actual=%h required=40800000", out_data); end
        checks++; if (out_id !== 2'd0) begin errors++; $display("FAIL add_id actual=%0d required=0", out_id); end
        @(negedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL add_valid_drop actual=%b required=0", out_valid); end
    endtask

    task automatic test_add_other();
        int n;
        set_ops(2, 32'h40000000, 32'h43800000, 1'b0);
        req_valid = 4'b0100;
        #1;
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL other_ready actual=%b required=0100", req_ready); end
        @(negedge clk);
        req_valid = 4'b0000;
        n = 0;
        #1;
        while (out_valid !== 1'b1 && n < 10) begin @(negedge clk); #1; n++; end
        checks++;
        if (n >= 10) begin errors++; $display("FAIL other_timeout actual=no_result required=result"); end
        else begin
            if (n !== 1) begin errors++; $display("FAIL other_latency actual=%0d required=1", n); end
            checks++; if (out_data !== 32'h43810000) begin errors++; $display("FAIL other_data actual=%h required=43810000", out_data); end
            checks++; if (out_id !== 2'd2) begin errors++; $display("FAIL other_id actual=%0d required=2", out_id); end
        end
        @(negedge clk);
    endtask

    task automatic test_sub_zero();
        int n;
        set_ops(1, 32'h42000040, 32'h42000040, 1'b1);
        req_valid = 4'b0010;
        #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL subz_ready actual=%b required=0010", req_ready); end
        @(negedge clk);
        req_valid = 4'b0000;
        n = 0;
        #1;
        while (out_valid !== 1'b1 && n < 10) begin @(negedge clk); #1; n++; end
        checks++;
        if (n >= 10) begin errors++; $display("FAIL subz_timeout actual=no_result required=result"); end
        else begin
            checks++; if (out_data !== 32'h00000000) begin errors++; $display("FAIL subz_data actual=%h required=00000000", out_data); end
            checks++; if (out_id !== 2'd1) begin errors++; $display("FAIL subz_id actual=%0d required=1", out_id); end
        end
        @(negedge clk);
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_ids [5];
        logic [1:0] ids [5];
        int cyc [5];
        int cnt;
        exp_ids = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        rst = 1'b1;
        req_valid = 4'hF;
        for (int i = 0; i < 4; i++) set_ops(i, 32'h3F800000, 32'h3F800000, 1'b0);
        out_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        cnt = 0;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (c == 0) begin
                checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL rr_first_ready actual=%b required=0001", req_ready); end
            end
            if (out_valid === 1'b1) begin
                ids[cnt] = out_id;
                cyc[cnt] = c;
                checks++; if (out_data !== 32'h40000000) begin errors++; $display("FAIL rr_data actual=%h required=40000000", out_data); end
                cnt++;
            end
            if (cnt == 5) break;
            @(negedge clk);
        end
        req_valid = 4'h0;
        checks++;
        if (cnt != 5) begin errors++; $display("FAIL rr_timeout actual=%0d required=5", cnt); end
        else begin
            checks++; if (cyc[0] != 2) begin errors++; $display("FAIL rr_first_latency actual=%0d required=2", cyc[0]); end
            for (int i = 0; i < 5; i++) begin
                checks++; if (ids[i] !== exp_ids[i]) begin errors++; $display("FAIL rr_id[%0d] actual=%0d required=%0d", i, ids[i], exp_ids[i]); end
            end
            for (int i = 0; i < 4; i++) begin
                checks++; if (cyc[i+1] - cyc[i] != 3) begin errors++; $display("FAIL rr_spacing[%0d] actual=%0d required=3", i, cyc[i+1] - cyc[i]); end
            end
        end
        @(negedge clk);
    endtask

    task automatic test_back_pressure();
        rst = 1'b1;
        req_valid = 4'h0;
        @(negedge clk);
        rst = 1'b0;
        set_ops(0, 32'h40000000, 32'h40000000, 1'b0);
        set_ops(3, 32'h40400000, 32'h3F800000, 1'b1);
        out_ready = 1'b0;
        req_valid = 4'b0001;
        @(negedge clk);
        req_valid = 4'b1000;
        #1;
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL bp_exec_ready actual=%b required=0000", req_ready); end
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d] actual=%b required=1", i, out_valid); end
            checks++; if (out_data !== 32'h40800000) begin errors++; $display("FAIL bp_data[%0d] actual=%h required=40800000", i, out_data); end
            checks++; if (out_id !== 2'd0) begin errors++; $display("FAIL bp_id[%0d] actual=%0d required=0", i, out_id); end
            checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL bp_ready[%0d] actual=%b required=0000", i, req_ready); end
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        #1;
        checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL bp_grant3 actual=%b required=1000", req_ready); end
        @(negedge clk);
        req_valid = 4'b0000;
        @(negedge clk);
        #1;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_r3_valid actual=%b required=1", out_valid); end
        checks++; if (out_data !== 32'h40000000) begin errors++; $display("FAIL bp_r3_data actual=%h required=40000000", out_data); end
        checks++; if (out_id !== 2'd3) begin errors++; $display("FAIL bp_r3_id actual=%0d required=3", out_id); end
        @(negedge clk);
`ifdef FP_ADD_ARBITER_STATS_EN
        #1;
        checks++; if (op_count !== 16'd2) begin errors++; $display("FAIL stats_ops actual=%0d required=2", op_count); end
        checks++; if (stall_count !== 16'd5) begin errors++; $display("FAIL stats_stalls actual=%0d required=5", stall_count); end
`endif
    endtask

    task automatic test_reset_exec();
        set_ops(1, 32'h3F800000, 32'h3F800000, 1'b0);
        req_valid = 4'b0010;
        #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL rex_first_ready actual=%b required=0010", req_ready); end
        @(negedge clk);
        rst = 1'b1;
        req_valid = 4'b1010;
        #1;
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL rex_ready_in_rst actual=%b required=0000", req_ready); end
        @(negedge clk);
        rst = 1'b0;
        set_ops(1, 32'h40000000, 32'h40000000, 1'b0);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rex_no_response actual=%b required=0", out_valid); end
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL rex_ptr_cleared actual=%b required=0010", req_ready); end
        @(negedge clk);
        req_valid = 4'b0000;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rex_exec_valid actual=%b required=0", out_valid); end
        @(negedge clk);
        #1;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rex_valid actual=%b required=1", out_valid); end
        checks++; if (out_data !== 32'h40800000) begin errors++; $display("FAIL rex_data actual=%h required=40800000", out_data); end
        checks++; if (out_id !== 2'd1) begin errors++; $display("FAIL rex_id actual=%0d required=1", out_id); end
        @(negedge clk);
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 4'h0;
        req_a     = '0;
        req_b     = '0;
        req_sub   = 4'h0;
        out_ready = 1'b1;
        @(negedge clk);
        test_reset();
        test_single_add();
        test_add_other();
        test_sub_zero();
        test_round_robin();
        test_back_pressure();
        test_reset_exec();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fp_add_arbiter.md
Name: fp_add_arbiter

Overview:
- Shares one combinational floating_unit (IEEE-754 single-precision add/subtract) among NUM_REQ requesters.
- Round-robin arbitration, valid/ready handshakes, registered operands and a registered result tagged with the requester index.
- Sits between the compute clients and the single floating_unit instance; the floating_unit is instantiated inside this block.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WIDTH, 32, operand/result width; must be 32 for floating_unit.
- ID_W, 2, width of the requester-index tag; must equal clog2(NUM_REQ).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- req_valid  input  NUM_REQ  per-requester operation request.
- req_ready  output  NUM_REQ  per-requester accept; one-hot or zero.
- req_a  input  NUM_REQ*WIDTH  operand A; requester i uses bits [i*WIDTH +: WIDTH].
- req_b  input  NUM_REQ*WIDTH  operand B, same packing as req_a.
- req_sub  input  NUM_REQ  1 = A-B, 0 = A+B.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts the result.
- out_data  output  WIDTH  floating_unit result.
- out_id  output  ID_W  index of the requester that issued the result.

Behaviour:
- Reset values: state=IDLE, rr_ptr=0, out_valid=0, out_data=0, out_id=0. req_ready=0 while rst=1.
- States: IDLE, EXEC, DONE.
- IDLE:
  - The grant goes to the first requester with req_valid=1, searching from rr_ptr upward with wrap-around.
  - req_ready[g]=1 combinationally for that requester only; all other req_ready bits are 0.
  - On the handshake, register a, b, sub and id=g; set rr_ptr=(g+1) mod NUM_REQ; go to EXEC.
  - No request: stay in IDLE.
- EXEC:
  - Registered operands drive floating_unit.
  - At the end of the cycle, capture its sum into out_data and id into out_id; set out_valid=1; go to DONE.
- DONE:
  - out_valid=1; out_data and out_id hold stable.
  - When out_ready=1, the result handshake completes, out_valid goes to 0 the next cycle, and the state returns to IDLE.
  - Otherwise stay in DONE indefinitely.
- req_ready=0 in EXEC and DONE.
- Latency: request handshake in cycle N; out_valid=1 in cycle N+2. Minimum issue interval is 3 cycles.
- Requesters must hold req_a, req_b and req_sub stable while req_valid=1 and unaccepted. Dropping req_valid before the grant is legal: that requester simply loses arbitration.
- Simultaneous requests: only one grant per IDLE cycle. A requester that is valid and is not granted keeps priority order. Worst-case wait is NUM_REQ-1 grants.
- Only the winner of a grant updates rr_ptr.
- Arithmetic, rounding, zero, infinity, NaN and denormal handling are entirely those of floating_unit; this block never alters the result.
- Reset mid-operation (EXEC or DONE):
  - The next cycle is IDLE with out_valid=0.
  - The in-flight result is discarded and no response is produced for it.
  - rr_ptr returns to 0.

Optional Feature:
- Macro: FP_ADD_ARBITER_STATS_EN.
- Defined:
  - Adds output op_count [15:0], cleared by rst.
  - Increments on each out_valid&&out_ready handshake and saturates at 16'hFFFF.
  - Adds output stall_count [15:0], which increments (saturating) each cycle in DONE with out_ready=0.
- Undefined: neither port nor counter exists, and all other behaviour is identical.

Test Plan:
- Single add:
  - Stimulus: after rst, req 0 issues a=32'h40000000, b=32'h40000000, sub=0, with out_ready=1.
  - Response: req_ready[0]=1 in the same cycle; 2 cycles later out_valid=1, out_data=32'h40800000, out_id=0.
- Add from another requester:
  - Stimulus: req 2 issues a=32'h40000000, b=32'h43800000, sub=0.
  - Response: out_data=32'h43810000, out_id=2.
- Subtract to zero:
  - Stimulus: req 1 issues a=32'h42000040, b=32'h42000040, sub=1.
  - Response: out_data=32'h00000000, out_id=1.
- Round-robin:
  - Stimulus: all 4 req_valid held high from reset, with out_ready=1.
  - Response: out_id sequence 0,1,2,3,0, with results spaced 3 cycles apart.
- Back-pressure:
  - Stimulus: out_ready=0 for 5 cycles while in DONE, with req 3 valid.
  - Response: out_data and out_id stable, req_ready=0 throughout; req 3 is granted on the first IDLE cycle after out_ready=1.
- Reset in EXEC:
  - Stimulus: assert rst for 1 cycle during EXEC.
  - Response: out_valid stays 0 and no response is produced for that operation. The next grant goes to the lowest valid index, since rr_ptr=0.
